amiga_chipram_dram_seq: RTL and testbench

Chip-RAM DRAM timing sequencer sitting directly downstream of the CAS-enable PAL. It consumes the PAL's RAM enable, RAM read/write and upper/lower byte-lane CAS enables. From these it produces the multiplexed row/column address, _RAS, _CASU/_CASL and _WE for the DRAM array. It also inserts CAS-before-RAS refresh cycles on an internal interval timer and reports completion of each access with a one-cycle RDY pulse.

---
 rtl/amiga_chipram_dram_seq_if.sv | 28 ++
 rtl/amiga_chipram_dram_seq.sv | 179 +++++++++++++++++
 tb/tb_amiga_chipram_dram_seq.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amiga_chipram_dram_seq_if.sv
// rtl/amiga_chipram_dram_seq_if.sv - CAS-PAL side inputs and DRAM-side outputs of the chip-RAM sequencer
interface amiga_chipram_dram_seq_if #(
    parameter int ROW_BITS = 9
);
    logic                    re_n;
    logic                    rrw;
    logic                    ucen;
    logic                    lcen;
    logic [2*ROW_BITS-1:0]   a;
    logic [ROW_BITS-1:0]     dram_a;
    logic                    ras_n;
    logic                    casu_n;
    logic                    casl_n;
    logic                    we_n;
    logic                    rdy;
    logic                    busy;
    logic                    ref_ovf;

    modport master (
        output re_n, rrw, ucen, lcen, a,
        input  dram_a, ras_n, casu_n, casl_n, we_n, rdy, busy, ref_ovf
    );

    modport slave (
        input  re_n, rrw, ucen, lcen, a,
        output dram_a, ras_n, casu_n, casl_n, we_n, rdy, busy, ref_ovf
    );
endinterface

// File: rtl/amiga_chipram_dram_seq.sv
// rtl/amiga_chipram_dram_seq.sv - chip-RAM DRAM timing sequencer with CBR refresh
module amiga_chipram_dram_seq #(
    parameter int ROW_BITS       = 9,
    parameter int RAS_TO_CAS     = 1,
    parameter int CAS_CYCLES     = 2,
    parameter int PRECHARGE      = 2,
    parameter int REF_INTERVAL   = 64,
    parameter int REF_RAS_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    amiga_chipram_dram_seq_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RCD, ST_COL, ST_CAS, ST_END, ST_PRE, ST_REF_CAS, ST_REF_RAS
    } state_t;

    localparam int M1      = (RAS_TO_CAS > CAS_CYCLES) ? RAS_TO_CAS : CAS_CYCLES;
    localparam int M2      = (PRECHARGE > REF_RAS_CYCLES) ? PRECHARGE : REF_RAS_CYCLES;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(REF_INTERVAL);
    localparam int PRE_CNT = (PRECHARGE > 1) ? PRECHARGE - 2 : 0;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TMR_W-1:0]    timer_q;
    logic [TMR_W-1:0]    timer_d;
    logic                wrap;
    logic                ref_req;
    logic                pend_q;
    logic                armed_q;
    logic                ovf_q;
    logic [ROW_BITS-1:0] lat_col_q;
    logic                lat_rrw_q;
    logic                lat_ucen_q;
    logic                lat_lcen_q;
    logic [ROW_BITS-1:0] dram_a_q;
    logic                ras_n_q;
    logic                casu_n_q;
    logic                casl_n_q;
    logic                we_n_q;
    logic                rdy_q;
    logic                busy_q;

    assign wrap    = (timer_q == TMR_W'(REF_INTERVAL - 1));
    assign timer_d = wrap ? '0 : timer_q + TMR_W'(1);
    // A wrap seen in IDLE is serviced on the same edge, ahead of any access.
    assign ref_req = pend_q | wrap;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            pend_q     <= 1'b0;
            armed_q    <= 1'b1;
            ovf_q      <= 1'b0;
            lat_col_q  <= '0;
            lat_rrw_q  <= 1'b1;
            lat_ucen_q <= 1'b0;
            lat_lcen_q <= 1'b0;
            dram_a_q   <= '0;
            ras_n_q    <= 1'b1;
            casu_n_q   <= 1'b1;
            casl_n_q   <= 1'b1;
            we_n_q     <= 1'b1;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            timer_q <= timer_d;
            rdy_q   <= 1'b0;
            if (bus.re_n)
                armed_q <= 1'b1;
            if (wrap && pend_q)
                ovf_q <= 1'b1;
            if (wrap)
                pend_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (ref_req) begin
                        pend_q   <= 1'b0;
                        casu_n_q <= 1'b0;
                        casl_n_q <= 1'b0;
                        ras_n_q  <= 1'b1;
                        we_n_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_REF_CAS;
                    end else if (!bus.re_n && armed_q) begin
                        lat_col_q  <= bus.a[ROW_BITS-1:0];
                        lat_rrw_q  <= bus.rrw;
                        lat_ucen_q <= bus.ucen;
                        lat_lcen_q <= bus.lcen;
                        armed_q    <= 1'b0;
                        dram_a_q   <= bus.a[2*ROW_BITS-1:ROW_BITS];
                        ras_n_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= CNT_W'(RAS_TO_CAS - 1);
                        state_q    <= ST_RCD;
                    end
                end
                ST_RCD: begin
                    if (cnt_q == '0) begin
                        dram_a_q <= lat_col_q;
                        we_n_q   <= lat_rrw_q;
                        state_q  <= ST_COL;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_COL: begin
                    casu_n_q <= !lat_ucen_q;
                    casl_n_q <= !lat_lcen_q;
                    cnt_q    <= CNT_W'(CAS_CYCLES - 1);
                    state_q  <= ST_CAS;
                end
                ST_CAS: begin
                    if (cnt_q == '0) begin
                        ras_n_q  <= 1'b1;
                        casu_n_q <= 1'b1;
                        casl_n_q <= 1'b1;
                        we_n_q   <= 1'b1;
                        rdy_q    <= 1'b1;
                        state_q  <= ST_END;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_END: begin
                    if (PRECHARGE > 1) begin
                        cnt_q   <= CNT_W'(PRE_CNT);
                        state_q <= ST_PRE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRE: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_REF_CAS: begin
                    ras_n_q <= 1'b0;
                    cnt_q   <= CNT_W'(REF_RAS_CYCLES - 1);
                    state_q <= ST_REF_RAS;
                end
                ST_REF_RAS: begin
                    // Refresh shares END/PRE with accesses but never pulses RDY.
                    if (cnt_q == '0) begin
                        ras_n_q  <= 1'b1;
                        casu_n_q <= 1'b1;
                        casl_n_q <= 1'b1;
                        we_n_q   <= 1'b1;
                        state_q  <= ST_END;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dram_a  = dram_a_q;
    assign bus.ras_n   = ras_n_q;
    assign bus.casu_n  = casu_n_q;
    assign bus.casl_n  = casl_n_q;
    assign bus.we_n    = we_n_q;
    assign bus.rdy     = rdy_q;
    assign bus.busy    = busy_q;
    assign bus.ref_ovf = ovf_q;

endmodule

// File: tb/tb_amiga_chipram_dram_seq.sv
// tb/tb_amiga_chipram_dram_seq.sv - bench for the chip-RAM DRAM sequencer
module tb_amiga_chipram_dram_seq;
    localparam int RB = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            re_n;
    logic            rrw;
    logic            ucen;
    logic            lcen;
    logic [2*RB-1:0] a;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    amiga_chipram_dram_seq_if #(.ROW_BITS(RB)) bus0 ();
    amiga_chipram_dram_seq_if #(.ROW_BITS(RB)) bus1 ();

    assign bus0.re_n = re_n;
    assign bus0.rrw  = rrw;
    assign bus0.ucen = ucen;
    assign bus0.lcen = lcen;
    assign bus0.a    = a;
    assign bus1.re_n = re_n;
    assign bus1.rrw  = rrw;
    assign bus1.ucen = ucen;
    assign bus1.lcen = lcen;
    assign bus1.a    = a;

    amiga_chipram_dram_seq #(.ROW_BITS(RB)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    amiga_chipram_dram_seq #(
        .ROW_BITS(RB), .RAS_TO_CAS(2), .CAS_CYCLES(40), .PRECHARGE(1),
        .REF_INTERVAL(16), .REF_RAS_CYCLES(3)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    // Per-instance timing parameters used by the model
    int p_r[2]  = '{1, 2};
    int p_c[2]  = '{2, 40};
    int p_p[2]  = '{2, 1};
    int p_rr[2] = '{2, 3};
    int p_ri[2] = '{64, 16};

    // Model: kind 0 = idle, 1 = access, 2 = refresh; outputs are a function of edges since start
    bit          m_valid = 1'b0;
    int          m_timer[2];
    bit          m_pend[2];
    bit          m_armed[2];
    bit          m_ovf[2];
    int          m_kind[2];
    int          m_start[2];
    logic [RB-1:0] m_row[2];
    logic [RB-1:0] m_col[2];
    bit          m_rrw[2];
    bit          m_u[2];
    bit          m_l[2];

    logic [RB-1:0] e_dram_a[2];
    bit e_ras[2], e_casu[2], e_casl[2], e_we[2], e_rdy[2], e_busy[2];

    task automatic model_step(input int k);
        int  d;
        int  acc_len;
        int  ref_len;
        bit  wrap;
        acc_len = p_r[k] + 1 + p_c[k] + p_p[k];
        ref_len = p_rr[k] + 1 + p_p[k];
        if (rst) begin
            m_valid     = 1'b1;
            m_timer[k]  = 0;
            m_pend[k]   = 1'b0;
            m_armed[k]  = 1'b1;
            m_ovf[k]    = 1'b0;
            m_kind[k]   = 0;
            e_dram_a[k] = '0;
        end else begin
            wrap       = (m_timer[k] == p_ri[k] - 1);
            m_timer[k] = wrap ? 0 : m_timer[k] + 1;
            d = edge_n - m_start[k];
            if (m_kind[k] == 1 && d > acc_len) m_kind[k] = 0;
            if (m_kind[k] == 2 && d > ref_len) m_kind[k] = 0;
            if (wrap && m_pend[k]) m_ovf[k] = 1'b1;
            if (m_kind[k] == 0 && (m_pend[k] || wrap)) begin
                m_kind[k]  = 2;
                m_start[k] = edge_n;
                m_pend[k]  = 1'b0;
            end else if (wrap) begin
                m_pend[k] = 1'b1;
            end
            if (m_kind[k] == 0 && !re_n && m_armed[k]) begin
                m_kind[k]  = 1;
                m_start[k] = edge_n;
                m_row[k]   = a[2*RB-1:RB];
                m_col[k]   = a[RB-1:0];
                m_rrw[k]   = rrw;
                m_u[k]     = ucen;
                m_l[k]     = lcen;
                m_armed[k] = 1'b0;
            end
            if (re_n) m_armed[k] = 1'b1;
        end
        d = edge_n - m_start[k];
        e_ras[k] = 1; e_casu[k] = 1; e_casl[k] = 1; e_we[k] = 1; e_rdy[k] = 0; e_busy[k] = 0;
        if (m_kind[k] == 1) begin
            if (d == 0) e_dram_a[k] = m_row[k];
            if (d == p_r[k]) e_dram_a[k] = m_col[k];
            e_ras[k]  = !(d < p_r[k] + 1 + p_c[k]);
            e_we[k]   = !(!m_rrw[k] && d >= p_r[k] && d < p_r[k] + 1 + p_c[k]);
            e_casu[k] = !(m_u[k] && d >= p_r[k] + 1 && d < p_r[k] + 1 + p_c[k]);
            e_casl[k] = !(m_l[k] && d >= p_r[k] + 1 && d < p_r[k] + 1 + p_c[k]);
            e_rdy[k]  = (d == p_r[k] + 1 + p_c[k]);
            e_busy[k] = (d < acc_len);
        end else if (m_kind[k] == 2) begin
            e_ras[k]  = !(d >= 1 && d <= p_rr[k]);
            e_casu[k] = !(d <= p_rr[k]);
            e_casl[k] = !(d <= p_rr[k]);
            e_busy[k] = (d < ref_len);
        end
    endtask

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (edge %0d)", nm, edge_n);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m0 dram_a", 32'(bus0.dram_a), 32'(e_dram_a[0]));
            chk("m0 ras_n",  32'(bus0.ras_n),  32'(e_ras[0]));
            chk("m0 casu_n", 32'(bus0.casu_n), 32'(e_casu[0]));
            chk("m0 casl_n", 32'(bus0.casl_n), 32'(e_casl[0]));
            chk("m0 we_n",   32'(bus0.we_n),   32'(e_we[0]));
            chk("m0 rdy",    32'(bus0.rdy),    32'(e_rdy[0]));
            chk("m0 busy",   32'(bus0.busy),   32'(e_busy[0]));
            chk("m0 ref_ovf", 32'(bus0.ref_ovf), 32'(m_ovf[0]));
            chk("m1 dram_a", 32'(bus1.dram_a), 32'(e_dram_a[1]));
            chk("m1 ras_n",  32'(bus1.ras_n),  32'(e_ras[1]));
            chk("m1 casu_n", 32'(bus1.casu_n), 32'(e_casu[1]));
            chk("m1 casl_n", 32'(bus1.casl_n), 32'(e_casl[1]));
            chk("m1 we_n",   32'(bus1.we_n),   32'(e_we[1]));
            chk("m1 rdy",    32'(bus1.rdy),    32'(e_rdy[1]));
            chk("m1 busy",   32'(bus1.busy),   32'(e_busy[1]));
            chk("m1 ref_ovf", 32'(bus1.ref_ovf), 32'(m_ovf[1]));
        end
    end

    initial begin
        int cnt;
        int guard;
        rst = 1'b1; re_n = 1'b1; rrw = 1'b1; ucen = 1'b0; lcen = 1'b0; a = '0;
        repeat (3) @(negedge clk);
        chk("rst ras_n",  32'(bus0.ras_n),  32'd1);
        chk("rst casu_n", 32'(bus0.casu_n), 32'd1);
        chk("rst casl_n", 32'(bus0.casl_n), 32'd1);
        chk("rst we_n",   32'(bus0.we_n),   32'd1);
        chk("rst dram_a", 32'(bus0.dram_a), 32'd0);
        chk("rst rdy",    32'(bus0.rdy),    32'd0);
        chk("rst busy",   32'(bus0.busy),   32'd0);
        chk("rst ovf",    32'(bus0.ref_ovf), 32'd0);
        rst = 1'b0;

        // Read, upper lane only
        a = 18'h2A5F3; rrw = 1'b1; ucen = 1'b1; lcen = 1'b0; re_n = 1'b0;
        @(negedge clk);
        chk("rd row", 32'(bus0.dram_a), 32'h152);
        chk("rd ras", 32'(bus0.ras_n), 32'd0);
        chk("mdl row", 32'(e_dram_a[0]), 32'h152);
        re_n = 1'b1;
        @(negedge clk);
        chk("rd col", 32'(bus0.dram_a), 32'h1F3);
        chk("rd we",  32'(bus0.we_n), 32'd1);
        @(negedge clk);
        chk("rd casu e2", 32'(bus0.casu_n), 32'd0);
        chk("rd casl e2", 32'(bus0.casl_n), 32'd1);
        @(negedge clk);
        chk("rd casu e3", 32'(bus0.casu_n), 32'd0);
        @(negedge clk);
        chk("rd rdy e4",  32'(bus0.rdy), 32'd1);
        chk("rd ras e4",  32'(bus0.ras_n), 32'd1);
        chk("rd casu e4", 32'(bus0.casu_n), 32'd1);
        @(negedge clk);
        chk("rd rdy e5",  32'(bus0.rdy), 32'd0);
        chk("rd busy e5", 32'(bus0.busy), 32'd1);
        @(negedge clk);
        chk("rd busy e6", 32'(bus0.busy), 32'd0);

        // Write, both lanes, _RE held low: a single access
        a = 18'($urandom); rrw = 1'b0; ucen = 1'b1; lcen = 1'b1; re_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) chk("wr we e1", 32'(bus0.we_n), 32'd0);
            if (i == 2) begin
                chk("wr casu e2", 32'(bus0.casu_n), 32'd0);
                chk("wr casl e2", 32'(bus0.casl_n), 32'd0);
            end
            if (i == 4) chk("wr we e4", 32'(bus0.we_n), 32'd1);
            cnt += int'(bus0.rdy);
        end
        chk("wr one rdy", 32'(cnt), 32'd1);
        re_n = 1'b1;
        @(negedge clk);

        // _RE released right after accept
        a = 18'($urandom); rrw = 1'b1; ucen = 1'b1; lcen = 1'b1; re_n = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) re_n = 1'b1;
            if (i == 2) chk("ab casu e2", 32'(bus0.casu_n), 32'd0);
            if (i == 4) chk("ab rdy e4", 32'(bus0.rdy), 32'd1);
            if (i == 5) chk("ab rdy e5", 32'(bus0.rdy), 32'd0);
        end
        @(negedge clk);

        // Reset during CAS
        a = 18'($urandom); rrw = 1'b0; ucen = 1'b1; lcen = 1'b0; re_n = 1'b0;
        @(negedge clk);
        re_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rc ras",  32'(bus0.ras_n), 32'd1);
        chk("rc casu", 32'(bus0.casu_n), 32'd1);
        chk("rc we",   32'(bus0.we_n), 32'd1);
        chk("rc busy", 32'(bus0.busy), 32'd0);
        chk("rc rdy",  32'(bus0.rdy), 32'd0);
        rst = 1'b0; re_n = 1'b0; a = 18'($urandom);
        @(negedge clk);
        chk("rc new ras",  32'(bus0.ras_n), 32'd0);
        chk("rc new busy", 32'(bus0.busy), 32'd1);
        re_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(bus0.rdy);
        end
        chk("rc one rdy", 32'(cnt), 32'd1);

        // Refresh wrap on the same edge the access is first seen
        guard = 0;
        while (!(m_timer[0] == p_ri[0] - 1 && bus0.busy == 1'b0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) bound_fail("col wait");
        a = 18'($urandom); rrw = 1'b1; ucen = 1'b1; lcen = 1'b1; re_n = 1'b0;
        @(negedge clk);
        chk("col casu", 32'(bus0.casu_n), 32'd0);
        chk("col casl", 32'(bus0.casl_n), 32'd0);
        chk("col ras1", 32'(bus0.ras_n), 32'd1);
        @(negedge clk);
        chk("col ras2", 32'(bus0.ras_n), 32'd0);
        @(negedge clk);
        chk("col ras3", 32'(bus0.ras_n), 32'd0);
        @(negedge clk);
        chk("col ras4", 32'(bus0.ras_n), 32'd1);
        chk("col rdy4", 32'(bus0.rdy), 32'd0);
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            cnt += int'(bus0.rdy);
        end
        chk("col one rdy", 32'(cnt), 32'd1);
        re_n = 1'b1;

        // Long accesses on the second instance straddle two wraps
        guard = 0;
        while (bus1.busy != 1'b0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) bound_fail("ovf wait");
        chk("ovf inst1", 32'(bus1.ref_ovf), 32'd1);
        chk("mdl ovf1",  32'(m_ovf[1]), 32'd1);
        chk("ovf inst0", 32'(bus0.ref_ovf), 32'd0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 3) == 0) re_n = ~re_n;
            rrw  = 1'($urandom_range(0, 1));
            ucen = 1'($urandom_range(0, 1));
            lcen = 1'($urandom_range(0, 1));
            a    = 18'($urandom);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
